// File: rtl/parking_sensor_frontend.sv
// Purpose : entrance/exit beam conditioning: 2-flop sync, debounce, rise pulse, stuck-beam fault.
// Latency : a stable raw change reaches the debounced level on edge DEBOUNCE_CYCLES+2; pulse is concurrent.
// Backpr. : none; free-running sample path, no handshake on any port.
//
// Ports (top):
//   clk, reset_n                 clock, asynchronous active-low reset
//   raw_entrance, raw_exit       raw beam inputs, asynchronous to clk, 1 = vehicle present
//   clear_fault                  synchronous request to clear stuck flags (honoured only once the level is 0)
//   sensor_entrance/sensor_exit  debounced levels, forced 0 while the channel is stuck
//   entrance_pulse/exit_pulse    one-cycle pulse on each debounced 0->1 transition
//   entrance_stuck/exit_stuck    sticky stuck-beam fault flags

// Purpose : one beam channel (sync, debounce, rise pulse, stuck detect).
// Latency : debounced level changes DEBOUNCE_CYCLES+2 edges after a stable raw change.
// Backpr. : none.
module parking_sensor_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic clear_fault,
    output logic sensor,
    output logic pulse,
    output logic stuck
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // debounced level 0
        ST_ACTIVE = 2'd1,   // debounced level 1, not yet timed out
        ST_STUCK  = 2'd2    // beam held too long; level keeps tracking underneath
    } state_t;

    localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STK_LAST  = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCNT_MAX  = {CNT_W{1'b1}};

    logic             s1, s2;
    logic             lvl, lvl_nxt;
    logic [7:0]       dcnt, dcnt_nxt;
    logic [CNT_W-1:0] scnt, scnt_nxt;
    state_t           state, state_nxt;
    logic             pulse_q, pulse_nxt;
    logic             timeout;

    // State register plus datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            lvl     <= 1'b0;
            dcnt    <= 8'd0;
            scnt    <= '0;
            state   <= ST_IDLE;
            pulse_q <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            lvl     <= lvl_nxt;
            dcnt    <= dcnt_nxt;
            scnt    <= scnt_nxt;
            state   <= state_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        lvl_nxt   = lvl;
        dcnt_nxt  = dcnt;
        scnt_nxt  = scnt;
        state_nxt = state;
        pulse_nxt = 1'b0;

        // Any sample matching the current level restarts the qualification count,
        // so a glitch shorter than DEBOUNCE_CYCLES samples never moves the level.
        if (s2 == lvl) begin
            dcnt_nxt = 8'd0;
        end else if (dcnt == DEB_LAST) begin
            lvl_nxt  = s2;
            dcnt_nxt = 8'd0;
        end else begin
            dcnt_nxt = dcnt + 8'd1;
        end

        // Stuck counter runs only while active; it holds (not wraps) at all-ones.
        timeout = (state == ST_ACTIVE) && lvl && (scnt == STK_LAST);
        if (!lvl) begin
            scnt_nxt = '0;
        end else if (state == ST_ACTIVE && scnt != SCNT_MAX) begin
            scnt_nxt = scnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (lvl_nxt) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (timeout)       state_nxt = ST_STUCK;
                else if (!lvl_nxt) state_nxt = ST_IDLE;
            end
            ST_STUCK: begin
                // Clear is honoured only once the beam has debounced back to 0.
                if (clear_fault && !lvl) state_nxt = lvl_nxt ? ST_ACTIVE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Rise pulse is suppressed if the channel is stuck on the edge of the rise.
        pulse_nxt = lvl_nxt && !lvl && (state != ST_STUCK);
    end

    // Outputs: decoded from flops only, so glitch-free.
    always_comb begin
        sensor = lvl && (state != ST_STUCK);
        stuck  = (state == ST_STUCK);
        pulse  = pulse_q;
    end

endmodule

// Purpose : two independent beam channels for the parking controller.
// Latency : DEBOUNCE_CYCLES+2 edges from stable raw change to level/pulse.
// Backpr. : none.
module parking_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_entrance,
    input  logic raw_exit,
    input  logic clear_fault,
    output logic sensor_entrance,
    output logic sensor_exit,
    output logic entrance_pulse,
    output logic exit_pulse,
    output logic entrance_stuck,
    output logic exit_stuck
);

    parking_sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) u_entrance (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (raw_entrance),
        .clear_fault (clear_fault),
        .sensor      (sensor_entrance),
        .pulse       (entrance_pulse),
        .stuck       (entrance_stuck)
    );

    parking_sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) u_exit (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (raw_exit),
        .clear_fault (clear_fault),
        .sensor      (sensor_exit),
        .pulse       (exit_pulse),
        .stuck       (exit_stuck)
    );

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Purpose : directed bench for parking_sensor_frontend (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20).
// Latency : inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpr. : n/a.
module tb_parking_sensor_frontend;

    logic clk = 1'b0;
    logic reset_n;
    logic raw_entrance, raw_exit, clear_fault;
    logic sensor_entrance, sensor_exit;
    logic entrance_pulse, exit_pulse;
    logic entrance_stuck, exit_stuck;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    parking_sensor_frontend #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (20),
        .CNT_W           (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .raw_entrance    (raw_entrance),
        .raw_exit        (raw_exit),
        .clear_fault     (clear_fault),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .entrance_pulse  (entrance_pulse),
        .exit_pulse      (exit_pulse),
        .entrance_stuck  (entrance_stuck),
        .exit_stuck      (exit_stuck)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All six outputs packed {sens_en, sens_ex, pul_en, pul_ex, stk_en, stk_ex}.
    function automatic logic [5:0] outs();
        return {sensor_entrance, sensor_exit, entrance_pulse, exit_pulse,
                entrance_stuck, exit_stuck};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        clear_fault  = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'(outs()), 32'h0);
        reset_n = 1'b1;
        tick();
        check("post_reset_outs", 32'(outs()), 32'h0);

        // 1: entrance rise, level and pulse on edge 6
        raw_entrance = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("ent_rise_lvl", 32'(sensor_entrance), 32'(j >= 6));
            check("ent_rise_pul", 32'(entrance_pulse), 32'(j == 6));
            check("ent_rise_exit", 32'({sensor_exit, exit_pulse}), 32'h0);
        end
        raw_entrance = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("ent_fall_lvl", 32'(sensor_entrance), 32'(j < 6));
            check("ent_fall_pul", 32'(entrance_pulse), 32'h0);
        end

        // 2: exit glitches of 1,2,3 cycles, then a real 10-cycle high
        for (int g = 1; g <= 3; g++) begin
            raw_exit = 1'b1;
            for (int j = 0; j < g; j++) begin
                tick();
                check("ex_glitch_hi", 32'({sensor_exit, exit_pulse}), 32'h0);
            end
            raw_exit = 1'b0;
            for (int j = 0; j < 5; j++) begin
                tick();
                check("ex_glitch_lo", 32'({sensor_exit, exit_pulse}), 32'h0);
            end
        end
        raw_exit = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check("ex_rise_lvl", 32'(sensor_exit), 32'(j >= 6));
            check("ex_rise_pul", 32'(exit_pulse), 32'(j == 6));
        end
        raw_exit = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("ex_fall_lvl", 32'(sensor_exit), 32'(j < 6));
        end

        // 3: simultaneous rise and fall on both channels
        raw_entrance = 1'b1;
        raw_exit     = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("both_rise_lvl", 32'({sensor_entrance, sensor_exit}), (j >= 6) ? 32'h3 : 32'h0);
            check("both_rise_pul", 32'({entrance_pulse, exit_pulse}), (j == 6) ? 32'h3 : 32'h0);
        end
        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check("both_fall_lvl", 32'({sensor_entrance, sensor_exit}), (j < 6) ? 32'h3 : 32'h0);
            check("both_fall_pul", 32'({entrance_pulse, exit_pulse}), 32'h0);
        end

        // 4: entrance held high until stuck (20 cycles after level rise)
        raw_entrance = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            check("stk_lvl", 32'(sensor_entrance), 32'((j >= 6) && (j < 26)));
            check("stk_flag", 32'(entrance_stuck), 32'(j >= 26));
            check("stk_pul", 32'(entrance_pulse), 32'(j == 6));
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("clr_while_hi_flag", 32'(entrance_stuck), 32'h1);
        check("clr_while_hi_lvl", 32'(sensor_entrance), 32'h0);
        tick();
        check("clr_while_hi_flag2", 32'(entrance_stuck), 32'h1);

        // 5: drop, debounce, then clear; next rise is normal
        raw_entrance = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("stk_drop_flag", 32'(entrance_stuck), 32'h1);
            check("stk_drop_lvl", 32'(sensor_entrance), 32'h0);
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("clr_flag", 32'(entrance_stuck), 32'h0);
        check("clr_outs", 32'(outs()), 32'h0);
        raw_entrance = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check("re_rise_lvl", 32'(sensor_entrance), 32'(j >= 6));
            check("re_rise_pul", 32'(entrance_pulse), 32'(j == 6));
            check("re_rise_flag", 32'(entrance_stuck), 32'h0);
        end
        raw_entrance = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        check("re_fall_outs", 32'(outs()), 32'h0);

        // 6: reset mid-debounce, exit already qualified high
        raw_exit = 1'b1;
        for (int j = 0; j < 7; j++) tick();
        check("pre_rst_exit", 32'(sensor_exit), 32'h1);
        raw_entrance = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_ent", 32'(sensor_entrance), 32'h0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_outs", 32'(outs()), 32'h0);
        tick();
        tick();
        check("mid_rst_hold", 32'(outs()), 32'h0);
        reset_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("rst_req_lvl", 32'({sensor_entrance, sensor_exit}), (j >= 6) ? 32'h3 : 32'h0);
            check("rst_req_pul", 32'({entrance_pulse, exit_pulse}), (j == 6) ? 32'h3 : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
